button_event_reader: RTL and testbench
======================================

Name: button_event_reader

Overview:
- Input-side counterpart to the LED output path: reads raw push-button/switch pins from the dedicated inputs.
- Synchronises and debounces each pin, then turns each debounced press and release into an event.
- Events are delivered one at a time over a valid/ready interface to downstream logic, such as an LED/display driver or a counter.
- Sits between the input pins and the user logic inside the top-level wrapper.

Parameters:
NUM_BTN, 4, number of button channels
IDX_W, 2, width of event index; must satisfy 2**IDX_W >= NUM_BTN
CNT_W, 16, debounce counter width
DEBOUNCE_CYCLES, 1000, consecutive stable cycles required to accept a new level; 1 <= value < 2**CNT_W

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
btn_raw  in  NUM_BTN  raw asynchronous button levels; 1 = pressed
btn_state  out  NUM_BTN  debounced level per channel
evt_valid  out  1  event available
evt_idx  out  IDX_W  channel index of the event
evt_press  out  1  1 = press (0->1), 0 = release (1->0)
evt_ready  in  1  consumer accepts the event when evt_valid && evt_ready
overflow  out  1  sticky: an event was lost
clr_overflow  in  1  clears overflow

Behaviour:
- Reset (rst=1 at a rising edge) clears everything to 0:
  - sync flops, counters, btn_state, pending bits, evt_valid, evt_idx, evt_press, overflow.
  - Any in-progress debounce is discarded.
- Synchroniser: two flops per channel. The sync output equals btn_raw delayed by 2 edges.
- Debounce, per channel, two states:
  - STABLE: sync == btn_state; counter held at 0.
  - COUNTING: sync != btn_state; counter increments each edge.
    - If sync returns to btn_state, go to STABLE and clear the counter. No event.
    - On the edge where the mismatch has lasted DEBOUNCE_CYCLES consecutive edges: btn_state toggles, counter clears, and the channel raises a flip.
- Latency: btn_state changes exactly DEBOUNCE_CYCLES+2 edges after the first edge that samples the new raw level.
- Pending store:
  - One pending bit plus one direction bit per channel.
  - A flip sets pending[i] and records the direction (new btn_state).
  - A flip while pending[i] is already set: overflow is set, the direction is overwritten with the newest, and the older event is lost.
- Output register (one entry):
  - Loads when evt_valid==0, or when evt_valid && evt_ready.
  - Takes the lowest-index channel with pending set, as seen at that edge (pre-update values), and clears that pending bit.
  - If nothing is pending, evt_valid goes to 0 on acceptance.
  - Latency from btn_state toggle to evt_valid = 1 edge when the output register is free.
- Handshake:
  - evt_valid, evt_idx and evt_press stay stable while evt_valid && !evt_ready.
  - Back-to-back events are allowed: a new event can appear on the edge of acceptance.
- Simultaneous events:
  - A flip on the same edge as its pending bit is consumed becomes a new pending event, with no overflow.
  - Multiple channels flipping together are queued and drained in ascending index order, one per accepted cycle.
- Overflow: cleared by clr_overflow. A set in the same cycle wins over clr_overflow.
- Channels with a raw level held high through reset produce a press event after reset deasserts, at the normal latency.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=4 and NUM_BTN=4.)
1. Clean press: raise btn_raw[0] and hold it, evt_ready=1.
   -> btn_state[0]=1 exactly 6 edges later.
   -> evt_valid=1 for one cycle on the next edge, with evt_idx=0, evt_press=1.
   -> Releasing the button yields evt_press=0 with the same timing.
2. Glitch: pulse btn_raw[1] high for 3 cycles.
   -> btn_state stays 0, evt_valid never asserts, overflow=0.
3. Simultaneous: raise btn_raw[2] and btn_raw[3] on the same edge, evt_ready=1.
   -> Event idx=2 then idx=3 on consecutive cycles, both with evt_press=1.
4. Backpressure: evt_ready=0; press btn0 (hold 8), release (hold 8), press again.
   -> First event (idx0, press) holds stable throughout.
   -> The third flip sets overflow=1.
   -> Raising evt_ready then delivers idx0 press followed by idx0 press (the overwritten direction).
   -> Pulsing clr_overflow clears overflow.
5. Reset mid-debounce: raise btn_raw[0], assert rst for 1 cycle at edge 4, keep raw high.
   -> All outputs are 0 after reset.
   -> btn_state[0]=1 exactly 6 edges after the first edge with rst=0.
   -> Exactly one press event follows.
6. Clear/set collision: assert clr_overflow on the same edge an overflow flip occurs.
   -> overflow=1 afterwards.

Source files
------------

// File: rtl/button_event_if.sv
// button_event_if: valid/ready channel that carries one button event at a time.
//   evt_valid : producer has an event
//   evt_idx   : channel index of the event
//   evt_press : 1 = press (0->1), 0 = release (1->0)
//   evt_ready : consumer takes the event when evt_valid && evt_ready
interface button_event_if #(parameter int IDX_W = 2);
  logic             evt_valid;
  logic [IDX_W-1:0] evt_idx;
  logic             evt_press;
  logic             evt_ready;
  modport master(output evt_valid, evt_idx, evt_press, input evt_ready);
  modport slave(input evt_valid, evt_idx, evt_press, output evt_ready);
endinterface

// File: rtl/button_event_reader.sv
// button_event_reader: synchronise and debounce button pins, emit press/release events over valid/ready.
//   clk, rst      : clock and synchronous active-high reset
//   btn_raw       : raw asynchronous button levels, 1 = pressed
//   btn_state     : debounced level per channel
//   overflow      : sticky, an event was lost; cleared by clr_overflow
//   clr_overflow  : clears overflow (a new loss in the same cycle wins)
//   evt           : event channel (master side)
module button_event_reader #(
  parameter int NUM_BTN         = 4,
  parameter int IDX_W           = 2,
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_state,
  output logic               overflow,
  input  logic               clr_overflow,
  button_event_if.master     evt
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [NUM_BTN-1:0] sync1, sync2, flip, pending, dir, take;
  logic [CNT_W-1:0]   cnt [NUM_BTN];
  logic [IDX_W-1:0]   sel;
  logic               load, any, ovf_set;
  always_comb begin
    flip = '0;
    sel  = '0;
    // descending scan leaves the lowest pending index in sel
    for (int i = NUM_BTN - 1; i >= 0; i--) if (pending[i]) sel = IDX_W'(i);
    // a flip fires on the edge the mismatch reaches DEBOUNCE_CYCLES consecutive edges
    for (int i = 0; i < NUM_BTN; i++) flip[i] = (sync2[i] != btn_state[i]) && (cnt[i] == LAST);
    any     = |pending;
    load    = !evt.evt_valid || evt.evt_ready;
    take    = (load && any) ? (NUM_BTN'(1) << sel) : '0;
    // a pending bit consumed on this edge frees its slot, so a flip there is not a loss
    ovf_set = |(flip & pending & ~take);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1         <= '0;
      sync2         <= '0;
      btn_state     <= '0;
      pending       <= '0;
      dir           <= '0;
      overflow      <= 1'b0;
      evt.evt_valid <= 1'b0;
      evt.evt_idx   <= '0;
      evt.evt_press <= 1'b0;
      for (int i = 0; i < NUM_BTN; i++) cnt[i] <= '0;
    end else begin
      sync1     <= btn_raw;
      sync2     <= sync1;
      for (int i = 0; i < NUM_BTN; i++)
        cnt[i] <= (sync2[i] == btn_state[i] || flip[i]) ? '0 : cnt[i] + CNT_W'(1);
      btn_state <= btn_state ^ flip;
      pending   <= (pending & ~take) | flip;
      dir       <= (dir & ~flip) | (~btn_state & flip);
      overflow  <= ovf_set | (overflow & ~clr_overflow);
      if (load) begin
        evt.evt_valid <= any;
        if (any) begin
          evt.evt_idx   <= sel;
          evt.evt_press <= dir[sel];
        end
      end
    end
  end
endmodule

// File: tb/tb_button_event_reader.sv
// tb_button_event_reader: directed checks plus a per-cycle reference model of the debounced event reader.
module tb_button_event_reader;
  localparam int NB = 4;
  localparam int IW = 2;
  localparam int CW = 16;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] btn_state;
  logic          overflow;
  logic          clr_overflow = 1'b0;

  button_event_if #(.IDX_W(IW)) evt_if();

  button_event_reader #(.NUM_BTN(NB), .IDX_W(IW), .CNT_W(CW), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_raw),
    .btn_state(btn_state),
    .overflow(overflow),
    .clr_overflow(clr_overflow),
    .evt(evt_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a channel's level flips once the last D synchronised samples
  // (raw taken two edges earlier) all disagree with it; events queue one slot per channel.
  logic [NB-1:0] win [0:D];
  logic [NB-1:0] mst, m_pend, m_dir;
  logic          m_valid, m_press, m_ovf;
  int            m_idx;
  bit            started = 0;
  int            log_q[$];

  always @(posedge clk) begin : model
    logic [NB-1:0] f;
    int            found;
    bit            oset;
    if (rst) begin
      for (int j = 0; j <= D; j++) win[j] = '0;
      mst = '0; m_pend = '0; m_dir = '0;
      m_valid = 0; m_press = 0; m_idx = 0; m_ovf = 0;
      started = 1;
    end else if (started) begin
      if (m_valid && evt_if.evt_ready) log_q.push_back(m_idx * 2 + int'(m_press));
      for (int i = 0; i < NB; i++) begin
        f[i] = 1'b1;
        for (int j = 1; j <= D; j++) if (win[j][i] == mst[i]) f[i] = 1'b0;
      end
      found = -1;
      for (int i = 0; i < NB; i++) if (m_pend[i] && found < 0) found = i;
      if (!m_valid || evt_if.evt_ready) begin
        m_valid = (found >= 0);
        if (found >= 0) begin
          m_idx = found;
          m_press = m_dir[found];
          m_pend[found] = 1'b0;
        end
      end
      oset = 0;
      for (int i = 0; i < NB; i++) if (f[i]) begin
        if (m_pend[i]) oset = 1;
        m_pend[i] = 1'b1;
        mst[i] = ~mst[i];
        m_dir[i] = mst[i];
      end
      m_ovf = oset ? 1'b1 : (clr_overflow ? 1'b0 : m_ovf);
      for (int j = D; j >= 1; j--) win[j] = win[j-1];
      win[0] = btn_raw;
    end
    #1;
    if (started) begin
      chk("m_btn_state", int'(btn_state), int'(mst));
      chk("m_overflow", int'(overflow), int'(m_ovf));
      chk("m_evt_valid", int'(evt_if.evt_valid), int'(m_valid));
      if (m_valid) begin
        chk("m_evt_idx", int'(evt_if.evt_idx), m_idx);
        chk("m_evt_press", int'(evt_if.evt_press), int'(m_press));
      end
    end
  end

  bit unstable = 0;
  bit seen_v   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(int i, logic lvl, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (btn_state[i] !== lvl && n < 40);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (evt_if.evt_valid !== 1'b1 && n < 40);
  endtask

  // hold inputs for k edges, watching that a held event never changes
  task automatic hold(int k);
    repeat (k) begin
      tick();
      if (seen_v && !evt_if.evt_valid) unstable = 1;
      if (evt_if.evt_valid) begin
        seen_v = 1;
        if (evt_if.evt_idx != 0 || !evt_if.evt_press) unstable = 1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n, ls, seen;
    evt_if.evt_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    chk("rst_btn_state", int'(btn_state), 0);
    chk("rst_valid", int'(evt_if.evt_valid), 0);
    chk("rst_idx", int'(evt_if.evt_idx), 0);
    chk("rst_press", int'(evt_if.evt_press), 0);
    chk("rst_overflow", int'(overflow), 0);

    // clean press and release
    @(negedge clk) btn_raw[0] = 1'b1;
    wait_state(0, 1'b1, n);
    chk("press_latency", n, 6);
    chk("valid_at_flip", int'(evt_if.evt_valid), 0);
    tick();
    chk("press_valid", int'(evt_if.evt_valid), 1);
    chk("press_idx", int'(evt_if.evt_idx), 0);
    chk("press_dir", int'(evt_if.evt_press), 1);
    tick();
    chk("press_one_cycle", int'(evt_if.evt_valid), 0);
    repeat (4) tick();
    @(negedge clk) btn_raw[0] = 1'b0;
    wait_state(0, 1'b0, n);
    chk("release_latency", n, 6);
    tick();
    chk("release_valid", int'(evt_if.evt_valid), 1);
    chk("release_idx", int'(evt_if.evt_idx), 0);
    chk("release_dir", int'(evt_if.evt_press), 0);

    // glitch shorter than the debounce window
    repeat (3) tick();
    @(negedge clk) btn_raw[1] = 1'b1;
    repeat (3) @(negedge clk);
    btn_raw[1] = 1'b0;
    seen = 0;
    repeat (15) begin
      tick();
      if (evt_if.evt_valid) seen = 1;
    end
    chk("glitch_no_event", seen, 0);
    chk("glitch_state", int'(btn_state), 0);
    chk("glitch_overflow", int'(overflow), 0);

    // simultaneous presses drain in index order
    @(negedge clk) btn_raw[3:2] = 2'b11;
    wait_valid(n);
    chk("simul_latency", n, 7);
    chk("simul_first_idx", int'(evt_if.evt_idx), 2);
    chk("simul_first_dir", int'(evt_if.evt_press), 1);
    tick();
    chk("simul_second_valid", int'(evt_if.evt_valid), 1);
    chk("simul_second_idx", int'(evt_if.evt_idx), 3);
    chk("simul_second_dir", int'(evt_if.evt_press), 1);
    tick();
    chk("simul_drained", int'(evt_if.evt_valid), 0);
    chk("simul_state", int'(btn_state), 12);
    @(negedge clk) btn_raw[3:2] = 2'b00;
    repeat (12) tick();
    chk("simul_released", int'(btn_state), 0);

    // backpressure with overwrite
    @(negedge clk);
    evt_if.evt_ready = 1'b0;
    unstable = 0;
    seen_v = 0;
    btn_raw[0] = 1'b1;
    hold(8);
    btn_raw[0] = 1'b0;
    hold(8);
    btn_raw[0] = 1'b1;
    hold(10);
    chk("bp_stable", int'(unstable), 0);
    chk("bp_overflow", int'(overflow), 1);
    chk("bp_held_valid", int'(evt_if.evt_valid), 1);
    chk("bp_held_idx", int'(evt_if.evt_idx), 0);
    chk("bp_held_dir", int'(evt_if.evt_press), 1);
    ls = log_q.size();
    evt_if.evt_ready = 1'b1;
    tick();
    chk("bp_next_valid", int'(evt_if.evt_valid), 1);
    chk("bp_next_idx", int'(evt_if.evt_idx), 0);
    chk("bp_next_dir", int'(evt_if.evt_press), 1);
    tick();
    chk("bp_drained", int'(evt_if.evt_valid), 0);
    chk("bp_log_count", log_q.size() - ls, 2);
    if (log_q.size() - ls == 2) begin
      chk("bp_log_first", log_q[ls], 1);
      chk("bp_log_second", log_q[ls+1], 1);
    end
    chk("bp_overflow_sticky", int'(overflow), 1);
    @(negedge clk) clr_overflow = 1'b1;
    @(negedge clk) clr_overflow = 1'b0;
    chk("bp_overflow_cleared", int'(overflow), 0);

    // reset in the middle of a debounce
    @(negedge clk) btn_raw[0] = 1'b0;
    repeat (12) tick();
    @(negedge clk) btn_raw[0] = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("mid_rst_state", int'(btn_state), 0);
    chk("mid_rst_valid", int'(evt_if.evt_valid), 0);
    chk("mid_rst_idx", int'(evt_if.evt_idx), 0);
    chk("mid_rst_press", int'(evt_if.evt_press), 0);
    chk("mid_rst_overflow", int'(overflow), 0);
    ls = log_q.size();
    wait_state(0, 1'b1, n);
    chk("post_rst_latency", n, 6);
    repeat (10) tick();
    chk("post_rst_events", log_q.size() - ls, 1);
    if (log_q.size() > ls) chk("post_rst_event", log_q[ls], 1);

    // overflow set collides with clear
    @(negedge clk);
    evt_if.evt_ready = 1'b0;
    btn_raw[1] = 1'b1;
    hold(8);
    btn_raw[1] = 1'b0;
    hold(8);
    btn_raw[1] = 1'b1;
    repeat (5) @(negedge clk);
    chk("coll_before", int'(overflow), 0);
    clr_overflow = 1'b1;
    @(negedge clk) clr_overflow = 1'b0;
    chk("coll_set_wins", int'(overflow), 1);
    chk("coll_state", int'(btn_state[1]), 1);
    @(negedge clk) clr_overflow = 1'b1;
    @(negedge clk) clr_overflow = 1'b0;
    chk("coll_cleared", int'(overflow), 0);
    evt_if.evt_ready = 1'b1;
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
